axi_read_arbiter: RTL and testbench

Shares the single AXI4 read master (AR/R channels) between two read requesters: requester 0 is instruction fetch and requester 1 is the upcoming data-load path. It accepts one burst request at a time and grants round-robin. It drives AR, then routes R beats back to the granted requester and checks the beat count and RID. It sits between the ifetch/load adapters and the M_AXI read ports in top, in the ACLK/ARST domain.

---
 rtl/axi_rd_pkg.sv | 20 ++
 rtl/rr_arb2.sv | 19 +
 rtl/axi_read_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_axi_read_arbiter.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_rd_pkg.sv
// Shared types and AXI constants for the read-side arbiter.
package axi_rd_pkg;

    // Arbiter FSM: wait for a request, present AR, then stream R beats.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_e;

    localparam logic [1:0] BURST_INCR    = 2'b01;
    localparam logic [1:0] RESP_OKAY     = 2'b00;
    localparam logic [3:0] CACHE_DEFAULT = 4'b0011;

    // ARSIZE encoding for a full-width beat: log2 of the bytes per beat.
    function automatic logic [2:0] axsize_for(input int data_w);
        return 3'($clog2(data_w / 8));
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin selector: favours the requester that did not win last.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       sel
);

    logic other;

    // Pick the non-last requester unless only the last one is asking.
    always_comb begin
        other = ~last;
        sel   = other;
        if (!req[other] && req[last]) begin
            sel = last;
        end
    end

endmodule

// File: rtl/axi_read_arbiter.sv
// Shares one AXI4 read master (AR/R) between instruction fetch (0) and data load (1).
// Handshakes: a transfer happens on a cycle where valid & ready are both high; a
// valid never waits for its ready, and a requester may drop valid before acceptance.
module axi_read_arbiter
    import axi_rd_pkg::*;
#(
    parameter int AXI_ID_W   = 1,
    parameter int AXI_ADDR_W = 32,
    parameter int AXI_DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rq0_valid,
    output logic                  rq0_ready,
    input  logic [AXI_ADDR_W-1:0] rq0_addr,
    input  logic [7:0]            rq0_len,
    output logic                  rs0_valid,
    input  logic                  rs0_ready,
    output logic [AXI_DATA_W-1:0] rs0_data,
    output logic [1:0]            rs0_resp,
    output logic                  rs0_last,
    input  logic                  rq1_valid,
    output logic                  rq1_ready,
    input  logic [AXI_ADDR_W-1:0] rq1_addr,
    input  logic [7:0]            rq1_len,
    output logic                  rs1_valid,
    input  logic                  rs1_ready,
    output logic [AXI_DATA_W-1:0] rs1_data,
    output logic [1:0]            rs1_resp,
    output logic                  rs1_last,
    output logic [AXI_ID_W-1:0]   M_AXI_ARID,
    output logic [AXI_ADDR_W-1:0] M_AXI_ARADDR,
    output logic [7:0]            M_AXI_ARLEN,
    output logic [2:0]            M_AXI_ARSIZE,
    output logic [1:0]            M_AXI_ARBURST,
    output logic                  M_AXI_ARLOCK,
    output logic [3:0]            M_AXI_ARCACHE,
    output logic [2:0]            M_AXI_ARPROT,
    output logic [3:0]            M_AXI_ARQOS,
    output logic                  M_AXI_ARVALID,
    input  logic                  M_AXI_ARREADY,
    input  logic [AXI_ID_W-1:0]   M_AXI_RID,
    input  logic [AXI_DATA_W-1:0] M_AXI_RDATA,
    input  logic [1:0]            M_AXI_RRESP,
    input  logic                  M_AXI_RLAST,
    input  logic                  M_AXI_RVALID,
    output logic                  M_AXI_RREADY,
    output logic                  busy,
    output logic                  grant,
    output logic                  proto_err,
    output logic [1:0]            dbg_state_o
);

    state_e                state_q, state_d;
    logic                  grant_q, grant_d;
    logic                  last_q, last_d;
    logic [AXI_ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]            len_q, len_d;
    logic [7:0]            cnt_q, cnt_d;
    logic                  perr_q, perr_d;

    logic                  sel;
    logic                  accept;
    logic                  r_hs;
    logic [AXI_ID_W-1:0]   grant_id;

    rr_arb2 u_rr (
        .req  ({rq1_valid, rq0_valid}),
        .last (last_q),
        .sel  (sel)
    );

    // Request side: ready is only offered to the selected requester while idle
    // and asking, so an idle bus with no requests shows both readies low.
    always_comb begin
        rq0_ready = (state_q == IDLE) && !sel && rq0_valid;
        rq1_ready = (state_q == IDLE) &&  sel && rq1_valid;
        accept    = rq0_ready || rq1_ready;
    end

    // AR channel: registered request fields, constant attributes.
    always_comb begin
        grant_id      = '0;
        grant_id[0]   = grant_q;
        M_AXI_ARID    = grant_id;
        M_AXI_ARADDR  = addr_q;
        M_AXI_ARLEN   = len_q;
        M_AXI_ARSIZE  = axsize_for(AXI_DATA_W);
        M_AXI_ARBURST = BURST_INCR;
        M_AXI_ARLOCK  = 1'b0;
        M_AXI_ARCACHE = CACHE_DEFAULT;
        M_AXI_ARPROT  = 3'd0;
        M_AXI_ARQOS   = 4'd0;
        M_AXI_ARVALID = (state_q == ADDR);
    end

    // R channel: zero-latency routing; payload fans out, only valid is steered.
    always_comb begin
        M_AXI_RREADY = (state_q == DATA) && (grant_q ? rs1_ready : rs0_ready);
        rs0_valid    = M_AXI_RVALID && (state_q == DATA) && !grant_q;
        rs1_valid    = M_AXI_RVALID && (state_q == DATA) &&  grant_q;
        rs0_data     = M_AXI_RDATA;
        rs1_data     = M_AXI_RDATA;
        rs0_resp     = M_AXI_RRESP;
        rs1_resp     = M_AXI_RRESP;
        rs0_last     = M_AXI_RLAST;
        rs1_last     = M_AXI_RLAST;
        r_hs         = M_AXI_RVALID && M_AXI_RREADY;
        busy         = (state_q != IDLE);
        grant        = grant_q;
        proto_err    = perr_q;
        dbg_state_o  = state_q;
    end

    // Next-state logic for the FSM, burst bookkeeping and the sticky error flag.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        addr_d  = addr_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        perr_d  = perr_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = ADDR;
                    grant_d = sel;
                    addr_d  = sel ? rq1_addr : rq0_addr;
                    len_d   = sel ? rq1_len : rq0_len;
                    cnt_d   = 8'd0;
                end
            end
            ADDR: begin
                if (M_AXI_ARREADY) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (r_hs) begin
                    cnt_d = cnt_q + 8'd1;
                    if (M_AXI_RLAST) begin
                        state_d = IDLE;
                        last_d  = grant_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A burst that overruns its length keeps streaming until RLAST.
        if (r_hs && M_AXI_RLAST && (cnt_q != len_q)) perr_d = 1'b1;
        if (r_hs && !M_AXI_RLAST && (cnt_q == len_q)) perr_d = 1'b1;
        if (r_hs && (M_AXI_RID != grant_id)) perr_d = 1'b1;
        if (M_AXI_RVALID && (state_q != DATA)) perr_d = 1'b1;
    end

    // State registers; last_q resets to 1 so requester 0 wins the first round.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= 1'b0;
            last_q  <= 1'b1;
            addr_q  <= '0;
            len_q   <= 8'd0;
            cnt_q   <= 8'd0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            perr_q  <= perr_d;
        end
    end

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Directed bench for axi_read_arbiter: a per-cycle vector table plus one
// hand-written burst with a random AR delay and a scoreboard on returned data.
module tb_axi_read_arbiter;
    import axi_rd_pkg::*;

    localparam int IDW = 1;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam logic [AW-1:0] A0 = 32'h0000_1000;
    localparam logic [AW-1:0] A1 = 32'h0000_2000;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          rq0_valid, rq0_ready, rs0_valid, rs0_ready, rs0_last;
    logic [AW-1:0] rq0_addr;
    logic [7:0]    rq0_len;
    logic [DW-1:0] rs0_data;
    logic [1:0]    rs0_resp;
    logic          rq1_valid, rq1_ready, rs1_valid, rs1_ready, rs1_last;
    logic [AW-1:0] rq1_addr;
    logic [7:0]    rq1_len;
    logic [DW-1:0] rs1_data;
    logic [1:0]    rs1_resp;
    logic [IDW-1:0] arid, rid;
    logic [AW-1:0] araddr;
    logic [7:0]    arlen;
    logic [2:0]    arsize, arprot;
    logic [1:0]    arburst, rresp;
    logic          arlock, arvalid, arready, rlast, rvalid, rready;
    logic [3:0]    arcache, arqos;
    logic [DW-1:0] rdata;
    logic          busy, grant, proto_err;
    logic [1:0]    dbg_state;

    axi_read_arbiter #(.AXI_ID_W(IDW), .AXI_ADDR_W(AW), .AXI_DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .rq0_valid(rq0_valid), .rq0_ready(rq0_ready), .rq0_addr(rq0_addr), .rq0_len(rq0_len),
        .rs0_valid(rs0_valid), .rs0_ready(rs0_ready), .rs0_data(rs0_data), .rs0_resp(rs0_resp),
        .rs0_last(rs0_last),
        .rq1_valid(rq1_valid), .rq1_ready(rq1_ready), .rq1_addr(rq1_addr), .rq1_len(rq1_len),
        .rs1_valid(rs1_valid), .rs1_ready(rs1_ready), .rs1_data(rs1_data), .rs1_resp(rs1_resp),
        .rs1_last(rs1_last),
        .M_AXI_ARID(arid), .M_AXI_ARADDR(araddr), .M_AXI_ARLEN(arlen), .M_AXI_ARSIZE(arsize),
        .M_AXI_ARBURST(arburst), .M_AXI_ARLOCK(arlock), .M_AXI_ARCACHE(arcache),
        .M_AXI_ARPROT(arprot), .M_AXI_ARQOS(arqos), .M_AXI_ARVALID(arvalid),
        .M_AXI_ARREADY(arready),
        .M_AXI_RID(rid), .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RLAST(rlast),
        .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready),
        .busy(busy), .grant(grant), .proto_err(proto_err), .dbg_state_o(dbg_state)
    );

    // ---------------- vector table ----------------
    typedef struct {
        string    nm;
        bit       rst;
        bit [1:0] rqv;
        bit [7:0] l0, l1;
        bit       arr, rv, rid, rl;
        bit [1:0] rsr;
        bit [1:0] e_rqr;
        bit       e_arv;
        bit [7:0] e_len;
        bit       e_rr;
        bit [1:0] e_rsv;
        bit       e_busy, e_gnt, e_perr;
    } vec_t;

    vec_t vecs[$];
    logic [DW-1:0] exp_q[$];
    int n_vec = 0;
    int n_bad = 0;

    task automatic add(input string nm, input bit r, input bit [1:0] rqv,
                       input bit [7:0] l0, input bit [7:0] l1, input bit arr,
                       input bit rv, input bit rd_id, input bit rl, input bit [1:0] rsr,
                       input bit [1:0] e_rqr, input bit e_arv, input bit [7:0] e_len,
                       input bit e_rr, input bit [1:0] e_rsv, input bit e_busy,
                       input bit e_gnt, input bit e_perr);
        vec_t t;
        t.nm = nm; t.rst = r; t.rqv = rqv; t.l0 = l0; t.l1 = l1; t.arr = arr;
        t.rv = rv; t.rid = rd_id; t.rl = rl; t.rsr = rsr;
        t.e_rqr = e_rqr; t.e_arv = e_arv; t.e_len = e_len; t.e_rr = e_rr;
        t.e_rsv = e_rsv; t.e_busy = e_busy; t.e_gnt = e_gnt; t.e_perr = e_perr;
        vecs.push_back(t);
    endtask

    // ---------------- scoreboard ----------------
    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        rq0_valid = 0; rq0_addr = '0; rq0_len = 0; rs0_ready = 0;
        rq1_valid = 0; rq1_addr = '0; rq1_len = 0; rs1_ready = 0;
        arready = 0; rid = '0; rdata = '0; rresp = RESP_OKAY; rlast = 0; rvalid = 0;
    endtask

    // Requester address/len are randomised whenever valid is low, so the
    // registered AR fields must not follow them.
    task automatic drive(input vec_t t, input logic [DW-1:0] d, input logic [1:0] rr);
        rst       = t.rst;
        rq0_valid = t.rqv[0];
        rq0_addr  = t.rqv[0] ? A0 : $urandom;
        rq0_len   = t.rqv[0] ? t.l0 : 8'($urandom);
        rq1_valid = t.rqv[1];
        rq1_addr  = t.rqv[1] ? A1 : $urandom;
        rq1_len   = t.rqv[1] ? t.l1 : 8'($urandom);
        arready   = t.arr;
        rvalid    = t.rv;
        rid       = t.rid;
        rlast     = t.rl;
        rdata     = d;
        rresp     = rr;
        rs0_ready = t.rsr[0];
        rs1_ready = t.rsr[1];
    endtask

    task automatic check_vec(input int i, input vec_t t, input logic [DW-1:0] d,
                             input logic [1:0] rr);
        string tag;
        tag = $sformatf("%s[%0d]", t.nm, i);
        chk({tag, ".flags"},
            {55'd0, rq1_ready, rq0_ready, arvalid, rready, rs1_valid, rs0_valid,
             busy, grant, proto_err},
            {55'd0, t.e_rqr, t.e_arv, t.e_rr, t.e_rsv, t.e_busy, t.e_gnt, t.e_perr});
        if (t.e_arv)
            chk({tag, ".ar"}, {23'd0, araddr, arlen, arid},
                {23'd0, (t.e_gnt ? A1 : A0), t.e_len, t.e_gnt});
        chk({tag, ".arconst"}, {45'd0, arsize, arburst, arlock, arcache, arprot, arqos},
            {45'd0, 3'd2, 2'b01, 1'b0, 4'b0011, 3'd0, 4'd0});
        chk({tag, ".rpass"}, {rs0_data, rs0_resp, rs0_last, rs1_resp, rs1_last, 26'd0},
            {d, rr, t.rl, rr, t.rl, 26'd0});
        chk({tag, ".rdata1"}, {32'd0, rs1_data}, {32'd0, d});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit pg;
        int dly;
        logic [DW-1:0] d;
        logic [1:0] rr;

        // Reset defaults, then first request from rq0 (len 0, ARREADY=1).
        add("reset", 1, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 2'b00, 0, 0, 0);
        add("reset", 1, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 2'b00, 0, 0, 0);
        add("reset", 1, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 2'b00, 0, 0, 0);
        add("acc0",  0, 2'b01, 0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 0, 0, 0, 2'b00, 0, 0, 0);
        add("ar0",   0, 2'b00, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 1, 0, 0, 2'b00, 1, 0, 0);
        add("beat0", 0, 2'b00, 0, 0, 0, 1, 0, 1, 2'b01, 2'b00, 0, 0, 1, 2'b01, 1, 0, 0);
        add("idle0", 0, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 2'b00, 0, 0, 0);

        // Contention: both valid continuously, len 3; last winner was 0.
        pg = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bit g;
            g = (k % 2 == 0);
            add("cont_acc", 0, 2'b11, 3, 3, 0, 0, 0, 0, 2'b00, g ? 2'b10 : 2'b01,
                0, 0, 0, 2'b00, 0, pg, 0);
            add("cont_ar", 0, 2'b11, 3, 3, 1, 0, 0, 0, 2'b00, 2'b00, 1, 3, 0, 2'b00, 1, g, 0);
            for (int b = 0; b < 4; b++)
                add("cont_beat", 0, 2'b11, 3, 3, 0, 1, g, (b == 3), 2'b11, 2'b00,
                    0, 0, 1, g ? 2'b10 : 2'b01, 1, g, 0);
            pg = g;
        end
        add("cont_drop", 0, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 2'b00, 0, 1, 0);

        // Backpressure on AR, then rs1_ready toggling.
        add("bp_acc", 0, 2'b10, 0, 2, 0, 0, 0, 0, 2'b00, 2'b10, 0, 0, 0, 2'b00, 0, 1, 0);
        for (int k = 0; k < 5; k++)
            add("bp_arwait", 0, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 2, 0, 2'b00, 1, 1, 0);
        add("bp_ar",   0, 2'b00, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 1, 2, 0, 2'b00, 1, 1, 0);
        add("bp_beat", 0, 2'b00, 0, 0, 0, 1, 1, 0, 2'b01, 2'b00, 0, 0, 0, 2'b10, 1, 1, 0);
        add("bp_beat", 0, 2'b00, 0, 0, 0, 1, 1, 0, 2'b10, 2'b00, 0, 0, 1, 2'b10, 1, 1, 0);
        add("bp_beat", 0, 2'b00, 0, 0, 0, 1, 1, 0, 2'b01, 2'b00, 0, 0, 0, 2'b10, 1, 1, 0);
        add("bp_beat", 0, 2'b00, 0, 0, 0, 1, 1, 0, 2'b10, 2'b00, 0, 0, 1, 2'b10, 1, 1, 0);
        add("bp_last", 0, 2'b00, 0, 0, 0, 1, 1, 1, 2'b10, 2'b00, 0, 0, 1, 2'b10, 1, 1, 0);
        add("bp_idle", 0, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 2'b00, 0, 1, 0);

        // Early RLAST: len 3, RLAST on beat 2.
        add("e1_acc",  0, 2'b01, 3, 0, 0, 0, 0, 0, 2'b00, 2'b01, 0, 0, 0, 2'b00, 0, 1, 0);
        add("e1_ar",   0, 2'b00, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 1, 3, 0, 2'b00, 1, 0, 0);
        add("e1_b0",   0, 2'b00, 0, 0, 0, 1, 0, 0, 2'b01, 2'b00, 0, 0, 1, 2'b01, 1, 0, 0);
        add("e1_b1",   0, 2'b00, 0, 0, 0, 1, 0, 1, 2'b01, 2'b00, 0, 0, 1, 2'b01, 1, 0, 0);
        add("e1_idle", 0, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 2'b00, 0, 0, 1);
        add("e1_rst",  1, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 2'b00, 0, 0, 1);

        // Missing RLAST: len 1, beat 2 without RLAST, RLAST on beat 3.
        add("e2_acc",  0, 2'b01, 1, 0, 0, 0, 0, 0, 2'b00, 2'b01, 0, 0, 0, 2'b00, 0, 0, 0);
        add("e2_ar",   0, 2'b00, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 1, 1, 0, 2'b00, 1, 0, 0);
        add("e2_b0",   0, 2'b00, 0, 0, 0, 1, 0, 0, 2'b01, 2'b00, 0, 0, 1, 2'b01, 1, 0, 0);
        add("e2_b1",   0, 2'b00, 0, 0, 0, 1, 0, 0, 2'b01, 2'b00, 0, 0, 1, 2'b01, 1, 0, 0);
        add("e2_b2",   0, 2'b00, 0, 0, 0, 1, 0, 1, 2'b01, 2'b00, 0, 0, 1, 2'b01, 1, 0, 1);
        add("e2_idle", 0, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 2'b00, 0, 0, 1);
        add("e2_rst",  1, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 2'b00, 0, 0, 1);

        // RID mismatch while granted to requester 1; flag is sticky.
        add("rid_acc",  0, 2'b10, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 0, 0, 0, 2'b00, 0, 0, 0);
        add("rid_ar",   0, 2'b00, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 1, 0, 0, 2'b00, 1, 1, 0);
        add("rid_b0",   0, 2'b00, 0, 0, 0, 1, 0, 1, 2'b10, 2'b00, 0, 0, 1, 2'b10, 1, 1, 0);
        add("rid_idle", 0, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 2'b00, 0, 1, 1);
        add("rid_hold", 0, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 2'b00, 0, 1, 1);
        add("rid_rst",  1, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 2'b00, 0, 1, 1);

        // Stray RVALID while idle: RREADY stays low, error flags.
        add("stray",      0, 2'b00, 0, 0, 0, 1, 0, 0, 2'b11, 2'b00, 0, 0, 0, 2'b00, 0, 0, 0);
        add("stray_idle", 0, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 2'b00, 0, 0, 1);
        add("stray_rst",  1, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 2'b00, 0, 0, 1);

        // Reset during DATA, then a normal burst.
        add("mr_acc",   0, 2'b01, 3, 0, 0, 0, 0, 0, 2'b00, 2'b01, 0, 0, 0, 2'b00, 0, 0, 0);
        add("mr_ar",    0, 2'b00, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 1, 3, 0, 2'b00, 1, 0, 0);
        add("mr_b0",    0, 2'b00, 0, 0, 0, 1, 0, 0, 2'b01, 2'b00, 0, 0, 1, 2'b01, 1, 0, 0);
        add("mr_rst",   1, 2'b00, 0, 0, 0, 1, 0, 0, 2'b01, 2'b00, 0, 0, 1, 2'b01, 1, 0, 0);
        add("mr_after", 0, 2'b00, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 0, 0, 0, 2'b00, 0, 0, 0);
        add("mr_acc2",  0, 2'b01, 1, 0, 0, 0, 0, 0, 2'b00, 2'b01, 0, 0, 0, 2'b00, 0, 0, 0);
        add("mr_ar2",   0, 2'b00, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 1, 1, 0, 2'b00, 1, 0, 0);
        add("mr_b0b",   0, 2'b00, 0, 0, 0, 1, 0, 0, 2'b01, 2'b00, 0, 0, 1, 2'b01, 1, 0, 0);
        add("mr_b1b",   0, 2'b00, 0, 0, 0, 1, 0, 1, 2'b01, 2'b00, 0, 0, 1, 2'b01, 1, 0, 0);
        add("mr_idle",  0, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 2'b00, 0, 0, 0);

        // Initial reset before the table so registers hold known values.
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);

        // Apply each vector after the falling edge; sample before the next rise.
        foreach (vecs[i]) begin
            @(negedge clk);
            d  = $urandom;
            rr = (i % 3 == 0) ? RESP_OKAY : 2'(i);
            drive(vecs[i], d, rr);
            #2;
            check_vec(i, vecs[i], d, rr);
        end

        // Hand sequence: rq1 burst of 6 with random AR delay; rq0 valid pulse
        // while busy must not be accepted.
        @(negedge clk);
        idle_inputs();
        rst = 1'b0;
        rq1_valid = 1; rq1_addr = 32'h0000_3040; rq1_len = 8'd5;
        #2 chk("hs_rq1_ready", {63'd0, rq1_ready}, 64'd1);
        @(negedge clk);
        rq1_valid = 0; rq1_addr = $urandom; rq1_len = 8'($urandom);
        rq0_valid = 1; rq0_addr = A0; rq0_len = 8'd7;
        #2 chk("hs_busy_no_rdy", {61'd0, rq0_ready, arvalid, grant}, 64'b011);
        @(negedge clk);
        rq0_valid = 0;
        dly = $urandom_range(1, 4);
        for (int k = 0; k < dly; k++) begin
            @(negedge clk);
            #2 chk("hs_ar_hold", {22'd0, arvalid, araddr, arlen, arid},
                   {22'd0, 1'b1, 32'h0000_3040, 8'd5, 1'b1});
        end
        @(negedge clk);
        arready = 1;
        #2 chk("hs_ar_hs", {63'd0, arvalid}, 64'd1);
        for (int b = 0; b < 6; b++) begin
            @(negedge clk);
            arready = 0; rvalid = 1; rid = 1'b1; rlast = (b == 5); rs1_ready = 1;
            rdata = $urandom;
            exp_q.push_back(rdata);
            #2 chk("hs_beat", {61'd0, rs1_valid, rs0_valid, rready}, 64'b101);
            if (rs1_valid && rs1_ready && exp_q.size() > 0)
                chk("hs_data", {32'd0, rs1_data}, {32'd0, exp_q.pop_front()});
        end
        @(negedge clk);
        rvalid = 0; rlast = 0; rs1_ready = 0;
        for (int k = 0; k < 10 && busy; k++) @(negedge clk);
        #2 chk("hs_done", {61'd0, busy, proto_err, grant}, 64'b001);
        chk("hs_queue_empty", {32'd0, 32'(exp_q.size())}, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
